seven_seg_scan_driver: RTL and testbench
========================================

SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot; legal range is 4 or more.
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 16, cycles at the start of each slot with all anodes off (anti-ghosting); legal range is 0 to REFRESH_DIV-2.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port right_digit, input, 4 bits: BCD digit for slot D0 (rightmost).
REQ-007 Port middle_digit, input, 4 bits: BCD digit for slot D1.
REQ-008 Port left_digit, input, 4 bits: BCD digit for slot D2.
REQ-009 Port sign, input, 1 bit: 1 means the product is negative and shows '-' in slot D3.
REQ-010 Port anode, output, 4 bits: active-low digit enables; bit n drives slot Dn.
REQ-011 Port seg, output, 7 bits: active-low segments in order {g,f,e,d,c,b,a}.

Function
REQ-012 A prescaler SHALL count 0..REFRESH_DIV-1; tick SHALL assert when count==REFRESH_DIV-1, and count SHALL wrap to 0 on that cycle.
REQ-013 The scan FSM states SHALL be D0 -> D1 -> D2 -> D3 -> D0, advancing only on tick, with no other transitions.
REQ-014 On tick in state D3, a snapshot register SHALL capture {sign, left_digit, middle_digit, right_digit}; displayed values SHALL come only from the snapshot, so a frame never tears.
REQ-015 anode and seg SHALL be registered, reflecting the current state and count with exactly 1 cycle latency.
REQ-016 While count < BLANK_CYCLES, anode SHALL be 4'b1111; otherwise exactly one anode bit, the current slot, SHALL be 0.
REQ-017 Slots D0-D2 SHALL show the decoded snapshot digit, with 0-9 in standard patterns (e.g. 0 -> 7'b1000000, 1 -> 7'b1111001).
REQ-018 A non-BCD digit value (10-15) SHALL drive seg=7'b1111111 (blank), and the slot timing SHALL stay unchanged.
REQ-019 Slot D3 SHALL show seg=7'b0111111 ('-') when the snapshot sign is 1, and 7'b1111111 otherwise.
REQ-020 Input changes outside the D3 tick SHALL have no effect on the outputs until the next snapshot.

Reset
REQ-021 While rst=1, count SHALL be 0, state D0, the snapshot all zeros, anode=4'b1111 and seg=7'b1111111.
REQ-022 Reset asserted mid-slot or mid-frame SHALL take effect at the next edge, with no partial-slot completion.
REQ-023 On the first edge after rst falls, the registers SHALL start from the reset values; the first visible digit (slot D0, value 0) SHALL appear once count reaches BLANK_CYCLES.

Configuration
REQ-024 With macro LEADING_ZERO_BLANK_EN defined, D2 SHALL be blank when its snapshot digit is 0, D1 SHALL be blank when D2 is blanked and its digit is 0, and D0 SHALL never be blanked.
REQ-025 With LEADING_ZERO_BLANK_EN undefined, all digits SHALL be shown as decoded, including leading zeros.

Structure
REQ-026 Package seven_seg_pkg SHALL hold the state encodings D0-D3, the segment constants SEG_BLANK, SEG_MINUS and SEG_DIGIT[0:9], and the anode-off constant.
REQ-027 The BCD-to-segment decode SHALL be a combinational sub-module, seven_seg_decode, instantiated once.

Verification
Benches SHALL use REFRESH_DIV=8 and BLANK_CYCLES=2.
REQ-028 Reset and scan: after reset release, anode SHALL be 1111 for cycles 1-2, 1110 for cycles 3-8, then blanked and 1101 in the next slot; the full anode sequence SHALL repeat every 32 cycles.
REQ-029 Digits and sign: drive left=4, middle=2, right=7, sign=1 before a D3 tick; the next frame SHALL show seg 0011001 on D2, 0100100 on D1, 1111000 on D0 and 0111111 on D3.
REQ-030 Tear-free: change right_digit from 7 to 3 while D1 is active; D0 SHALL show 7 for the rest of that frame and 3 from the following frame.
REQ-031 Invalid BCD: right_digit=4'hC SHALL give seg=1111111 during D0 with the anode still asserted.
REQ-032 Leading-zero blanking: with LEADING_ZERO_BLANK_EN defined and digits 0,0,5, D2 and D1 SHALL show 1111111 and D0 SHALL show 0010010; with the macro undefined, D2 and D1 SHALL show 1000000.
REQ-033 Reset mid-frame: assert rst during D2 at count=5; on the next edge anode SHALL be 1111, the state D0 and the snapshot 0.

Source files
------------

// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: scan-slot encodings,
// active-low segment patterns {g,f,e,d,c,b,a}, anode constants and the snapshot record.
package seven_seg_pkg;

  localparam logic [1:0] ST_D0 = 2'd0;
  localparam logic [1:0] ST_D1 = 2'd1;
  localparam logic [1:0] ST_D2 = 2'd2;
  localparam logic [1:0] ST_D3 = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // One complete frame's worth of inputs, latched together so a frame never mixes values.
  typedef struct packed {
    logic       sign;
    logic [3:0] left;
    logic [3:0] middle;
    logic [3:0] right;
  } snapshot_t;

  function automatic logic [3:0] anode_for(input logic [1:0] slot);
    return ~(4'b0001 << slot);
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Display bundle: BCD digits and sign into the driver, multiplexed anode/segment drive out.
interface seven_seg_scan_driver_if;

  logic [3:0] right_digit;
  logic [3:0] middle_digit;
  logic [3:0] left_digit;
  logic       sign;
  logic [3:0] anode;
  logic [6:0] seg;

  modport master (
    output right_digit, middle_digit, left_digit, sign,
    input  anode, seg
  );

  modport slave (
    input  right_digit, middle_digit, left_digit, sign,
    output anode, seg
  );

endinterface

// File: rtl/seven_seg_scan_driver_decode.sv
// Combinational BCD to active-low seven-segment decode; values 10-15 decode to blank.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (digit_i <= 4'd9) begin
      seg_o = SEG_DIGIT[digit_i];
    end
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Four-slot multiplexed seven-segment scanner with per-slot anti-ghost blanking
// and a frame snapshot. Define LEADING_ZERO_BLANK_EN to suppress leading zeros on D2/D1.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input logic                    clk,
  input logic                    rst,
  seven_seg_scan_driver_if.slave disp
);

  localparam int               CNT_W     = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  if (REFRESH_DIV < 4) begin : g_bad_div
    $error("REFRESH_DIV must be at least 4");
  end
  if (BLANK_CYCLES < 0 || BLANK_CYCLES > REFRESH_DIV - 2) begin : g_bad_blank
    $error("BLANK_CYCLES must be in 0..REFRESH_DIV-2");
  end

  logic [CNT_W-1:0] count_q, count_d;
  logic             tick;
  logic [1:0]       state_q, state_d;
  snapshot_t        snap_q, snap_d;
  logic [3:0]       anode_q, anode_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       digit_sel;
  logic [6:0]       digit_seg;
  logic             digit_blank;

  always_comb begin
    tick    = (count_q == CNT_LAST);
    count_d = tick ? '0 : count_q + CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        ST_D0:   state_d = ST_D1;
        ST_D1:   state_d = ST_D2;
        ST_D2:   state_d = ST_D3;
        default: state_d = ST_D0;
      endcase
    end
  end

  // New inputs are only taken at the frame boundary, so D0..D3 always show the same sample.
  always_comb begin
    snap_d = snap_q;
    if (tick && state_q == ST_D3) begin
      snap_d.sign   = disp.sign;
      snap_d.left   = disp.left_digit;
      snap_d.middle = disp.middle_digit;
      snap_d.right  = disp.right_digit;
    end
  end

  always_comb begin
    case (state_q)
      ST_D0:   digit_sel = snap_q.right;
      ST_D1:   digit_sel = snap_q.middle;
      ST_D2:   digit_sel = snap_q.left;
      default: digit_sel = 4'd0;
    endcase
  end

  seven_seg_decode u_decode (
    .digit_i (digit_sel),
    .seg_o   (digit_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // D1 is only suppressed when D2 was suppressed too; D0 always shows.
  always_comb begin
    case (state_q)
      ST_D2:   digit_blank = (snap_q.left == 4'd0);
      ST_D1:   digit_blank = (snap_q.left == 4'd0) && (snap_q.middle == 4'd0);
      default: digit_blank = 1'b0;
    endcase
  end
`else
  assign digit_blank = 1'b0;
`endif

  always_comb begin
    anode_d = (count_q < CNT_BLANK) ? ANODE_OFF : anode_for(state_q);
    if (state_q == ST_D3) begin
      seg_d = snap_q.sign ? SEG_MINUS : SEG_BLANK;
    end else if (digit_blank) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = digit_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      state_q <= ST_D0;
      snap_q  <= '0;
      anode_q <= ANODE_OFF;
      seg_q   <= SEG_BLANK;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      snap_q  <= snap_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
    end
  end

  assign disp.anode = anode_q;
  assign disp.seg   = seg_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver (REFRESH_DIV=8, BLANK_CYCLES=2);
// follows LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_seven_seg_scan_driver;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] PBLANK = 7'b1111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  seven_seg_scan_driver_if dispIf();

  seven_seg_scan_driver #(
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .disp (dispIf)
  );

  always #5 clk = ~clk;

  int vecCount  = 0;
  int missCount = 0;
  int tbCyc     = 0;
  bit checkEn   = 1'b0;

  // Reference: a frame is 32 cycles of four 8-cycle slots; outputs lag by one edge.
  logic [6:0]  digitPat [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  int          mCyc;
  logic [12:0] mSnap;
  logic [3:0]  expAnode;
  logic [6:0]  expSeg;

  function automatic logic [3:0] anodeFor(input int c);
    if ((c % 8) < 2) return 4'b1111;
    case ((c / 8) % 4)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [6:0] segFor(input int c, input logic [12:0] s);
    int slot;
    int d;
    slot = (c / 8) % 4;
    if (slot == 3) return s[12] ? 7'b0111111 : 7'b1111111;
    d = (slot == 0) ? int'(s[3:0]) : (slot == 1) ? int'(s[7:4]) : int'(s[11:8]);
    if (LZB && slot == 2 && s[11:8] == 4'd0) return 7'b1111111;
    if (LZB && slot == 1 && s[11:8] == 4'd0 && s[7:4] == 4'd0) return 7'b1111111;
    if (d > 9) return 7'b1111111;
    return digitPat[d];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mCyc     <= 0;
      mSnap    <= '0;
      expAnode <= 4'b1111;
      expSeg   <= 7'b1111111;
    end else begin
      expAnode <= anodeFor(mCyc);
      expSeg   <= segFor(mCyc, mSnap);
      if ((mCyc % 32) == 31)
        mSnap <= {dispIf.sign, dispIf.left_digit, dispIf.middle_digit, dispIf.right_digit};
      mCyc <= mCyc + 1;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      vecCount++;
      if (dispIf.anode !== expAnode || dispIf.seg !== expSeg) begin
        missCount++;
        $display("[TB] FAIL model t=%0t anode=%b want %b seg=%b want %b",
                 $time, dispIf.anode, expAnode, dispIf.seg, expSeg);
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] l, input logic [3:0] m,
                               input logic [3:0] r, input logic s);
    dispIf.left_digit   = l;
    dispIf.middle_digit = m;
    dispIf.right_digit  = r;
    dispIf.sign         = s;
  endtask

  task automatic stepTo(input int target);
    while (tbCyc < target) begin
      @(negedge clk);
      tbCyc++;
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] wantAnode,
                             input logic [6:0] wantSeg);
    vecCount++;
    if (dispIf.anode !== wantAnode) begin
      missCount++;
      $display("[TB] FAIL %s anode: got %b want %b", name, dispIf.anode, wantAnode);
    end
    vecCount++;
    if (dispIf.seg !== wantSeg) begin
      missCount++;
      $display("[TB] FAIL %s seg: got %b want %b", name, dispIf.seg, wantSeg);
    end
  endtask

  task automatic pinModel(input string name, input logic [3:0] wantAnode,
                          input logic [6:0] wantSeg);
    vecCount++;
    if (expAnode !== wantAnode || expSeg !== wantSeg) begin
      missCount++;
      $display("[TB] FAIL %s model: got %b/%b want %b/%b",
               name, expAnode, expSeg, wantAnode, wantSeg);
    end
  endtask

  initial begin
    applyStimulus(4'd0, 4'd0, 4'd0, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("reset", 4'b1111, PBLANK);

    applyStimulus(4'd4, 4'd2, 4'd7, 1'b1);
    rst   = 1'b0;
    tbCyc = 0;
    stepTo(1);  checkOutput("cyc1",  4'b1111, P0);
    stepTo(2);  checkOutput("cyc2",  4'b1111, P0);
    stepTo(3);  checkOutput("cyc3",  4'b1110, P0);
    stepTo(8);  checkOutput("cyc8",  4'b1110, P0);
    stepTo(9);  checkOutput("cyc9",  4'b1111, LZB ? PBLANK : P0);
    stepTo(11); checkOutput("cyc11", 4'b1101, LZB ? PBLANK : P0);
    stepTo(27); checkOutput("frame1D3", 4'b0111, PBLANK);

    stepTo(35); checkOutput("digitD0", 4'b1110, 7'b1111000);
    pinModel("digitD0", 4'b1110, 7'b1111000);
    stepTo(42); applyStimulus(4'd4, 4'd2, 4'd3, 1'b1);
    stepTo(43); checkOutput("digitD1", 4'b1101, 7'b0100100);
    stepTo(51); checkOutput("digitD2", 4'b1011, 7'b0011001);
    stepTo(59); checkOutput("signD3",  4'b0111, 7'b0111111);
    pinModel("signD3", 4'b0111, 7'b0111111);

    stepTo(67); checkOutput("tearNewD0", 4'b1110, 7'b0110000);
    stepTo(68); applyStimulus(4'd4, 4'd2, 4'hC, 1'b1);
    stepTo(69); checkOutput("tearHoldD0", 4'b1110, 7'b0110000);
    stepTo(99); checkOutput("invalidBcd", 4'b1110, PBLANK);

    stepTo(100); applyStimulus(4'd0, 4'd0, 4'd5, 1'b0);
    stepTo(131); checkOutput("lzD0", 4'b1110, 7'b0010010);
    stepTo(139); checkOutput("lzD1", 4'b1101, LZB ? PBLANK : P0);
    stepTo(147); checkOutput("lzD2", 4'b1011, LZB ? PBLANK : P0);
    stepTo(155); checkOutput("noSign", 4'b0111, PBLANK);

    while (tbCyc < 405) begin
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0)
        applyStimulus(4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 1'b0);
      stepTo(tbCyc + 1);
    end

    rst = 1'b1;
    stepTo(406); checkOutput("midReset", 4'b1111, PBLANK);
    rst   = 1'b0;
    tbCyc = 0;
    stepTo(3);  checkOutput("afterReset", 4'b1110, P0);
    stepTo(27); checkOutput("afterResetD3", 4'b0111, PBLANK);
    stepTo(40);

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
